// File: rtl/pistormx_arb_pkg.sv
// Shared types and constants for the PistormX bus-mastership arbiter:
// one-hot state encoding, default timing constants and counter sizing.
`default_nettype none

package pistormx_arb_pkg;

    typedef enum logic [4:0] {
        OWN      = 5'b00001,
        WAIT_END = 5'b00010,
        GRANT    = 5'b00100,
        DMA      = 5'b01000,
        HOLDOFF  = 5'b10000
    } arb_state_t;

    localparam int DEF_TIMEOUT_CYCLES = 255;
    localparam int DEF_HOLDOFF_CYCLES = 4;

    // Bits needed to hold the larger of the two cycle limits.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pistormx_sync2.sv
// Two-flop synchroniser with a selectable reset value, for asynchronous
// 68000 bus-arbitration inputs.
`default_nettype none

module pistormx_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pistormx_bus_arbiter.sv
// 68000 BR/BG/BGACK bus-mastership arbiter gating the Pi transfer engine.
// Optional grant timeout enabled by defining ARB_GRANT_TIMEOUT_EN.
`default_nettype none

module pistormx_bus_arbiter
    import pistormx_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES
) (
    input  logic M68K_CLK,
    input  logic M68K_RESET_n,
    input  logic M68K_BR_n,
    input  logic M68K_BGACK_n,
    output logic M68K_BG_n,
    input  logic CYC_REQ,
    input  logic CYC_ACTIVE,
    output logic CYC_ALLOW,
    output logic BUS_RELEASE,
    output logic DMA_ACTIVE,
    output logic ARB_TIMEOUT
);

    localparam int CW = cnt_width(TIMEOUT_CYCLES, HOLDOFF_CYCLES);

    logic          br_n_sync;
    logic          bgack_n_sync;
    logic          br;
    logic          bgack;
    arb_state_t    state;
    arb_state_t    nxt;
    logic [CW-1:0] cnt;
    logic          prev_active;
    logic          timeout_hit;
    logic          unused_cyc_req;

    // Pending-request status does not influence arbitration decisions.
    assign unused_cyc_req = CYC_REQ;

    pistormx_sync2 #(.RESET_VAL(1'b1)) u_sync_br (
        .clk   (M68K_CLK),
        .rst_n (M68K_RESET_n),
        .d     (M68K_BR_n),
        .q     (br_n_sync)
    );

    pistormx_sync2 #(.RESET_VAL(1'b1)) u_sync_bgack (
        .clk   (M68K_CLK),
        .rst_n (M68K_RESET_n),
        .d     (M68K_BGACK_n),
        .q     (bgack_n_sync)
    );

    assign br    = ~br_n_sync;
    assign bgack = ~bgack_n_sync;

    always_comb begin
        nxt         = state;
        timeout_hit = 1'b0;
        case (state)
            OWN: begin
                if (bgack)
                    nxt = DMA;
                else if (br)
                    nxt = WAIT_END;
            end
            WAIT_END: begin
                // Require CYC_ACTIVE low on two consecutive edges so a cycle
                // launched on the entry edge is seen before granting.
                if (!br)
                    nxt = OWN;
                else if (!CYC_ACTIVE && !prev_active)
                    nxt = GRANT;
            end
            GRANT: begin
                if (bgack)
                    nxt = DMA;
                else if (!br)
                    nxt = OWN;
`ifdef ARB_GRANT_TIMEOUT_EN
                else if (int'(cnt) + 1 >= TIMEOUT_CYCLES) begin
                    nxt         = HOLDOFF;
                    timeout_hit = 1'b1;
                end
`endif
            end
            DMA: begin
                if (!bgack)
                    nxt = (HOLDOFF_CYCLES == 0) ? OWN : HOLDOFF;
            end
            HOLDOFF: begin
                if (int'(cnt) + 1 >= HOLDOFF_CYCLES)
                    nxt = OWN;
            end
            default: nxt = OWN;
        endcase
    end

    always_ff @(posedge M68K_CLK or negedge M68K_RESET_n) begin
        if (!M68K_RESET_n) begin
            state       <= OWN;
            cnt         <= '0;
            prev_active <= 1'b0;
            M68K_BG_n   <= 1'b1;
            CYC_ALLOW   <= 1'b1;
            BUS_RELEASE <= 1'b0;
            DMA_ACTIVE  <= 1'b0;
            ARB_TIMEOUT <= 1'b0;
        end else begin
            state       <= nxt;
            prev_active <= CYC_ACTIVE;
            if (nxt != state)
                cnt <= '0;
            else if (cnt != '1)
                cnt <= cnt + 1'b1;
            // Outputs decoded from the next state so they change on the
            // same edge as the transition.
            M68K_BG_n   <= (nxt != GRANT);
            CYC_ALLOW   <= (nxt == OWN) || (nxt == HOLDOFF);
            BUS_RELEASE <= (nxt == GRANT) || (nxt == DMA);
            DMA_ACTIVE  <= (nxt == DMA);
            ARB_TIMEOUT <= timeout_hit;
        end
    end

endmodule

`default_nettype wire
